// File: rtl/segre_pkg.sv
// rtl/segre_pkg.sv - shared dcache geometry constants and miss controller state type
package segre_pkg;

   localparam int DCACHE_NUM_LANES  = 4;
   localparam int DCACHE_INDEX_SIZE = $clog2(DCACHE_NUM_LANES);
   localparam int DCACHE_TAG_SIZE   = 20;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MISS_REQ  = 2'd1,
      MISS_WAIT = 2'd2,
      FILL      = 2'd3
   } dcache_miss_state_t;

endpackage

// File: rtl/segre_dcache_victim_ptr.sv
// rtl/segre_dcache_victim_ptr.sv - round-robin victim lane pointer with clear-on-invalidate
module segre_dcache_victim_ptr
   import segre_pkg::*;
#(
   parameter int NUM_LANES = DCACHE_NUM_LANES,
   parameter int WIDTH     = DCACHE_INDEX_SIZE
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] ptr_o
);

   // Clear beats increment so an invalidate during a fill still restarts at lane 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_o <= '0;
      end else if (clr_i) begin
         ptr_o <= '0;
      end else if (inc_i) begin
         if (ptr_o == WIDTH'(NUM_LANES - 1))
            ptr_o <= '0;
         else
            ptr_o <= ptr_o + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/segre_dcache_miss_ctrl.sv
// rtl/segre_dcache_miss_ctrl.sv - dcache miss FSM: MMU line fetch and tag-array fill
// Optional perf counters enabled by SEGRE_DCACHE_MISS_PERF_EN.
module segre_dcache_miss_ctrl
   import segre_pkg::*;
#(
   parameter int NUM_LANES  = DCACHE_NUM_LANES,
   parameter int INDEX_SIZE = DCACHE_INDEX_SIZE,
   parameter int TAG_SIZE   = DCACHE_TAG_SIZE
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic [TAG_SIZE-1:0]   tag_i,
   input  logic                  hit_i,
   input  logic                  miss_i,
   input  logic                  invalidate_i,
   output logic                  mmu_req_o,
   output logic [TAG_SIZE-1:0]   mmu_tag_o,
   input  logic                  mmu_gnt_i,
   input  logic                  mmu_valid_i,
   output logic                  fill_o,
   output logic [INDEX_SIZE-1:0] fill_index_o,
   output logic [TAG_SIZE-1:0]   fill_tag_o,
   output logic                  stall_o,
   output logic                  busy_o
`ifdef SEGRE_DCACHE_MISS_PERF_EN
   ,
   output logic [31:0]           miss_count_o,
   output logic [31:0]           stall_cycles_o
`endif
);

   dcache_miss_state_t    state_q;
   logic [TAG_SIZE-1:0]   miss_tag_q;
   logic [INDEX_SIZE-1:0] fill_index_q;
   logic [TAG_SIZE-1:0]   fill_tag_q;
   logic [INDEX_SIZE-1:0] victim_ptr;
   logic                  miss_start;

   assign miss_start = (state_q == IDLE) & req_i & miss_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         miss_tag_q   <= '0;
         fill_index_q <= '0;
         fill_tag_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_i && miss_i) begin
                  miss_tag_q <= tag_i;
                  state_q    <= MISS_REQ;
               end
            end
            MISS_REQ: begin
               if (mmu_gnt_i && mmu_valid_i)
                  state_q <= FILL;
               else if (mmu_gnt_i)
                  state_q <= MISS_WAIT;
            end
            MISS_WAIT: begin
               if (mmu_valid_i)
                  state_q <= FILL;
            end
            FILL: begin
               fill_index_q <= victim_ptr;
               fill_tag_q   <= miss_tag_q;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   segre_dcache_victim_ptr #(
      .NUM_LANES (NUM_LANES),
      .WIDTH     (INDEX_SIZE)
   ) u_victim_ptr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (state_q == FILL),
      .clr_i (invalidate_i),
      .ptr_o (victim_ptr)
   );

   // Fill fields are live during FILL and hold their last written values otherwise.
   assign mmu_req_o    = (state_q == MISS_REQ);
   assign mmu_tag_o    = miss_tag_q;
   assign fill_o       = (state_q == FILL);
   assign fill_index_o = fill_o ? victim_ptr : fill_index_q;
   assign fill_tag_o   = fill_o ? miss_tag_q : fill_tag_q;
   assign busy_o       = (state_q != IDLE);
   assign stall_o      = busy_o | miss_start;

`ifdef SEGRE_DCACHE_MISS_PERF_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         miss_count_o   <= '0;
         stall_cycles_o <= '0;
      end else begin
         if (miss_start && (miss_count_o != 32'hFFFF_FFFF))
            miss_count_o <= miss_count_o + 32'd1;
         if (stall_o && (stall_cycles_o != 32'hFFFF_FFFF))
            stall_cycles_o <= stall_cycles_o + 32'd1;
      end
   end
`endif

   a_hit_miss_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
      !(hit_i && miss_i))
      else $error("hit_i and miss_i asserted together");

   a_stray_mmu_valid: assert property (@(posedge clk_i) disable iff (rst_i)
      !(mmu_valid_i && ((state_q == IDLE) || ((state_q == MISS_REQ) && !mmu_gnt_i))))
      else $warning("mmu_valid_i ignored outside an accepted fetch");

endmodule
